// File: rtl/ipv4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_pkg
// Description : Shared types and constants for the IPv4 header checker and
//               its TX checksum counterpart.
// Revision    : 1.0 - initial release
// ============================================================================
package ipv4_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_t;

    localparam logic [3:0]  IPV4_VERSION = 4'd4;
    localparam logic [3:0]  IHL_MIN      = 4'd5;
    localparam logic [15:0] CSUM_GOOD    = 16'hFFFF;

    // Field positions within header word 0
    localparam int VER_MSB   = 31;
    localparam int VER_LSB   = 28;
    localparam int IHL_MSB   = 27;
    localparam int IHL_LSB   = 24;
    localparam int TLEN_MSB  = 15;
    localparam int TLEN_LSB  = 0;
    // Protocol position within header word 2
    localparam int PROTO_MSB = 23;
    localparam int PROTO_LSB = 16;

    // Word indices carrying protocol, source and destination
    localparam logic [3:0] W_PROTO = 4'd2;
    localparam logic [3:0] W_SRC   = 4'd3;
    localparam logic [3:0] W_DST   = 4'd4;

endpackage
`default_nettype wire

// File: rtl/ipv4_hdr_check_if.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_hdr_check_if
// Description : Header word stream in, checked result out (valid/ready both).
// Revision    : 1.0 - initial release
// ============================================================================
interface ipv4_hdr_check_if;

    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic [31:0] in_data;

    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic        res_csum_err;
    logic        res_ver_err;
    logic        res_ihl_err;
    logic        res_len_err;
    logic [15:0] res_total_len;
    logic [7:0]  res_proto;
    logic [31:0] res_src;
    logic [31:0] res_dst;

    modport master (
        output in_valid, in_sop, in_data, res_ready,
        input  in_ready, res_valid, res_ok, res_csum_err, res_ver_err,
               res_ihl_err, res_len_err, res_total_len, res_proto,
               res_src, res_dst
    );

    modport slave (
        input  in_valid, in_sop, in_data, res_ready,
        output in_ready, res_valid, res_ok, res_csum_err, res_ver_err,
               res_ihl_err, res_len_err, res_total_len, res_proto,
               res_src, res_dst
    );

endinterface
`default_nettype wire

// File: rtl/csum_fold.sv
`default_nettype none
// ============================================================================
// Module      : csum_fold
// Description : Combinational 3-input 16-bit ones'-complement adder.
// Revision    : 1.0 - initial release
// ============================================================================
module csum_fold (
    input  wire logic [15:0] i_acc,
    input  wire logic [15:0] i_hi,
    input  wire logic [15:0] i_lo,
    output logic      [15:0] o_sum
);

    logic [17:0] w_s;
    logic [16:0] w_t;

    // Two end-around carry stages absorb the up-to-2-bit overflow of 3 addends
    assign w_s   = {2'b00, i_acc} + {2'b00, i_hi} + {2'b00, i_lo};
    assign w_t   = {1'b0, w_s[15:0]} + {15'd0, w_s[17:16]};
    assign o_sum = w_t[15:0] + {15'd0, w_t[16]};

endmodule
`default_nettype wire

// File: rtl/ipv4_hdr_check.sv
`default_nettype none
// ============================================================================
// Module      : ipv4_hdr_check
// Description : RX IPv4 header checker: ones'-complement sum, field checks,
//               extracted fields. Optional counters under IPV4_CHK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ipv4_hdr_check
    import ipv4_pkg::*;
`ifdef IPV4_CHK_STATS_EN
#(
    parameter int STATS_W = 16
)
`endif
(
    input  wire logic       clk,
    input  wire logic       reset,
    ipv4_hdr_check_if.slave bus
`ifdef IPV4_CHK_STATS_EN
    ,
    output logic [STATS_W-1:0] stat_good,
    output logic [STATS_W-1:0] stat_bad,
    output logic [STATS_W-1:0] stat_abort
`endif
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_in_ready;
    logic        w_res_valid;

    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [3:0]  r_ver;
    logic [3:0]  r_ihl;
    logic [15:0] r_total_len;
    logic [7:0]  r_proto;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic        r_ok;
    logic        r_csum_err;
    logic        r_ver_err;
    logic        r_ihl_err;
    logic        r_len_err;

    logic        w_xfer;
    logic        w_start;
    logic        w_abort;
    logic        w_accept;
    logic        w_last;
    logic        w_res_hs;
    logic [3:0]  w_ihl_eff;
    logic        w_cnt_done;
    logic [15:0] w_acc_base;
    logic [15:0] w_acc_next;
    logic        w_csum_err;
    logic        w_ver_err;
    logic        w_ihl_err;
    logic        w_len_err;

    assign w_xfer     = bus.in_valid & w_in_ready;
    assign w_start    = w_xfer & bus.in_sop;
    assign w_abort    = w_start & (r_state == ACCUM);
    assign w_accept   = w_xfer & ~bus.in_sop & (r_state == ACCUM);
    assign w_ihl_eff  = (r_ihl < IHL_MIN) ? IHL_MIN : r_ihl;
    assign w_cnt_done = ((r_cnt + 4'd1) == w_ihl_eff);
    assign w_last     = w_accept & w_cnt_done;
    assign w_res_hs   = w_res_valid & bus.res_ready;

    // A start-of-packet word always begins a fresh sum, even when aborting
    assign w_acc_base = w_start ? 16'd0 : r_acc;

    csum_fold u_fold (
        .i_acc (w_acc_base),
        .i_hi  (bus.in_data[31:16]),
        .i_lo  (bus.in_data[15:0]),
        .o_sum (w_acc_next)
    );

    assign w_csum_err = (w_acc_next != CSUM_GOOD);
    assign w_ver_err  = (r_ver != IPV4_VERSION);
    assign w_ihl_err  = (r_ihl < IHL_MIN);
    assign w_len_err  = (r_total_len < {10'd0, r_ihl, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && bus.in_sop) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && !bus.in_sop && w_cnt_done) w_state_nxt = RESULT;
            end
            RESULT: begin
                w_res_valid = 1'b1;
                if (bus.res_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= 16'd0;
            r_cnt       <= 4'd0;
            r_ver       <= 4'd0;
            r_ihl       <= 4'd0;
            r_total_len <= 16'd0;
            r_proto     <= 8'd0;
            r_src       <= 32'd0;
            r_dst       <= 32'd0;
            r_ok        <= 1'b0;
            r_csum_err  <= 1'b0;
            r_ver_err   <= 1'b0;
            r_ihl_err   <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            if (w_start) begin
                r_acc       <= w_acc_next;
                r_cnt       <= 4'd1;
                r_ver       <= bus.in_data[VER_MSB:VER_LSB];
                r_ihl       <= bus.in_data[IHL_MSB:IHL_LSB];
                r_total_len <= bus.in_data[TLEN_MSB:TLEN_LSB];
            end else if (w_accept) begin
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + 4'd1;
                case (r_cnt)
                    W_PROTO: r_proto <= bus.in_data[PROTO_MSB:PROTO_LSB];
                    W_SRC:   r_src   <= bus.in_data;
                    W_DST:   r_dst   <= bus.in_data;
                    default: ;
                endcase
            end
            // Flags latch with the final word so they stay frozen in RESULT
            if (w_last) begin
                r_csum_err <= w_csum_err;
                r_ver_err  <= w_ver_err;
                r_ihl_err  <= w_ihl_err;
                r_len_err  <= w_len_err;
                r_ok       <= ~(w_csum_err | w_ver_err | w_ihl_err | w_len_err);
            end
        end
    end

`ifdef IPV4_CHK_STATS_EN
    logic [STATS_W-1:0] r_stat_good;
    logic [STATS_W-1:0] r_stat_bad;
    logic [STATS_W-1:0] r_stat_abort;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_good  <= '0;
            r_stat_bad   <= '0;
            r_stat_abort <= '0;
        end else begin
            if (w_res_hs && r_ok && (r_stat_good != '1))   r_stat_good  <= r_stat_good + 1'b1;
            if (w_res_hs && !r_ok && (r_stat_bad != '1))   r_stat_bad   <= r_stat_bad + 1'b1;
            if (w_abort && (r_stat_abort != '1))           r_stat_abort <= r_stat_abort + 1'b1;
        end
    end

    assign stat_good  = r_stat_good;
    assign stat_bad   = r_stat_bad;
    assign stat_abort = r_stat_abort;
`else
    logic w_unused;
    assign w_unused = w_res_hs | w_abort;
`endif

    assign bus.in_ready      = w_in_ready;
    assign bus.res_valid     = w_res_valid;
    assign bus.res_ok        = r_ok;
    assign bus.res_csum_err  = r_csum_err;
    assign bus.res_ver_err   = r_ver_err;
    assign bus.res_ihl_err   = r_ihl_err;
    assign bus.res_len_err   = r_len_err;
    assign bus.res_total_len = r_total_len;
    assign bus.res_proto     = r_proto;
    assign bus.res_src       = r_src;
    assign bus.res_dst       = r_dst;

endmodule
`default_nettype wire

// File: tb/tb_ipv4_hdr_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_ipv4_hdr_check
// Description : Randomized self-checking bench for ipv4_hdr_check with a
//               whole-header checksum reference model (IPV4_CHK_STATS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ipv4_hdr_check;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ipv4_hdr_check_if bus ();

`ifdef IPV4_CHK_STATS_EN
    logic [15:0] stat_good, stat_bad, stat_abort;
    ipv4_hdr_check #(.STATS_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .stat_good  (stat_good),
        .stat_bad   (stat_bad),
        .stat_abort (stat_abort)
    );
`else
    ipv4_hdr_check dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] hdr [16];
    int          hdr_n;

    logic        e_ok, e_csum_err, e_ver_err, e_ihl_err, e_len_err;
    logic [15:0] e_total_len;
    logic [7:0]  e_proto;
    logic [31:0] e_src, e_dst;
    int          exp_good = 0, exp_bad = 0, exp_abort = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Whole-header ones'-complement sum, folded once at the end
    function automatic logic [15:0] ref_sum();
        int unsigned t = 0;
        for (int i = 0; i < hdr_n; i++) t += hdr[i][31:16] + hdr[i][15:0];
        while (t > 32'h0000_FFFF) t = (t & 32'h0000_FFFF) + (t >> 16);
        return t[15:0];
    endfunction

    task automatic compute_expected();
        logic [31:0] w0;
        logic [3:0]  ver, ihl;
        w0          = hdr[0];
        ver         = w0[31:28];
        ihl         = w0[27:24];
        e_total_len = w0[15:0];
        e_proto     = hdr[2][23:16];
        e_src       = hdr[3];
        e_dst       = hdr[4];
        e_csum_err  = (ref_sum() != 16'hFFFF);
        e_ver_err   = (ver != 4'd4);
        e_ihl_err   = (ihl < 4'd5);
        e_len_err   = (int'(e_total_len) < 4 * int'(ihl));
        e_ok        = !(e_csum_err || e_ver_err || e_ihl_err || e_len_err);
    endtask

    task automatic build(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] tlen,
                         input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                         input bit opt_rand, input bit corrupt);
        logic [15:0] csum;
        hdr_n  = (ihl < 4'd5) ? 5 : int'(ihl);
        hdr[0] = {ver, ihl, 8'h00, tlen};
        hdr[1] = {16'($urandom), 16'h4000};
        hdr[2] = {8'h40, proto, 16'h0000};
        hdr[3] = src;
        hdr[4] = dst;
        for (int i = 5; i < hdr_n; i++) hdr[i] = opt_rand ? 32'($urandom) : 32'h0;
        csum = ~ref_sum();
        hdr[2][15:0] = corrupt ? (csum ^ 16'h0100) : csum;
    endtask

    task automatic set_ref_hdr();
        hdr_n  = 5;
        hdr[0] = 32'h4500_0073;
        hdr[1] = 32'h0000_4000;
        hdr[2] = 32'h4011_B861;
        hdr[3] = 32'hC0A8_0001;
        hdr[4] = 32'hC0A8_00C7;
    endtask

    task automatic send_word(input logic [31:0] d, input logic sop);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sop   = sop;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_sop   = 1'b0;
    endtask

    task automatic get_result(input int delay);
        int guard = 0;
        while (!bus.res_valid && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        check("res_valid",     64'(bus.res_valid),     64'd1);
        check("res_ok",        64'(bus.res_ok),        64'(e_ok));
        check("res_csum_err",  64'(bus.res_csum_err),  64'(e_csum_err));
        check("res_ver_err",   64'(bus.res_ver_err),   64'(e_ver_err));
        check("res_ihl_err",   64'(bus.res_ihl_err),   64'(e_ihl_err));
        check("res_len_err",   64'(bus.res_len_err),   64'(e_len_err));
        check("res_total_len", 64'(bus.res_total_len), 64'(e_total_len));
        check("res_proto",     64'(bus.res_proto),     64'(e_proto));
        check("res_src",       64'(bus.res_src),       64'(e_src));
        check("res_dst",       64'(bus.res_dst),       64'(e_dst));
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("hold_in_ready",  64'(bus.in_ready),  64'd0);
            check("hold_res_valid", 64'(bus.res_valid), 64'd1);
            check("hold_ok",        64'(bus.res_ok),    64'(e_ok));
            check("hold_src",       64'(bus.res_src),   64'(e_src));
            check("hold_dst",       64'(bus.res_dst),   64'(e_dst));
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        if (e_ok) exp_good++;
        else      exp_bad++;
        check("post_hs_valid", 64'(bus.res_valid), 64'd0);
`ifdef IPV4_CHK_STATS_EN
        check("stat_good", 64'(stat_good), 64'(exp_good));
        check("stat_bad",  64'(stat_bad),  64'(exp_bad));
`endif
    endtask

    task automatic send_header();
        compute_expected();
        for (int i = 0; i < hdr_n; i++) begin
            if (i == hdr_n - 1) check("pre_last_valid", 64'(bus.res_valid), 64'd0);
            send_word(hdr[i], (i == 0));
        end
        check("latency_valid", 64'(bus.res_valid), 64'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready),      64'd1);
        check({tag, "_res_valid"}, 64'(bus.res_valid),     64'd0);
        check({tag, "_flags"},     64'({bus.res_ok, bus.res_csum_err, bus.res_ver_err,
                                         bus.res_ihl_err, bus.res_len_err}), 64'd0);
        check({tag, "_tlen"},      64'(bus.res_total_len), 64'd0);
        check({tag, "_proto"},     64'(bus.res_proto),     64'd0);
        check({tag, "_src"},       64'(bus.res_src),       64'd0);
        check({tag, "_dst"},       64'(bus.res_dst),       64'd0);
`ifdef IPV4_CHK_STATS_EN
        check({tag, "_stats"},     64'({stat_good, stat_bad, stat_abort}), 64'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ver, ihl;
        logic [15:0] tlen;
        int          r;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_sop    = 1'b0;
        bus.in_data   = 32'h0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset");

        // Reference header, good checksum
        set_ref_hdr();
        send_header();
        get_result(0);

        // Same header with a wrong checksum
        set_ref_hdr();
        hdr[2] = 32'h4011_B862;
        send_header();
        check("bad_csum_model", 64'(e_csum_err), 64'd1);
        get_result(1);

        // IHL=6 with a zero option word
        build(4'd4, 4'd6, 16'h0077, 8'h11, 32'hC0A8_0001, 32'hC0A8_00C7, 1'b0, 1'b0);
        send_header();
        get_result(0);

        // Version 6, then IHL 4 (five words still consumed)
        build(4'd6, 4'd5, 16'h0040, 8'h06, 32'h0A00_0001, 32'h0A00_0002, 1'b0, 1'b0);
        send_header();
        get_result(0);
        build(4'd4, 4'd4, 16'h0040, 8'h06, 32'h0A00_0003, 32'h0A00_0004, 1'b0, 1'b0);
        send_header();
        get_result(0);

        // Length boundary: total_len exactly 4*IHL, then one less
        build(4'd4, 4'd7, 16'd28, 8'h01, 32'h0102_0304, 32'h0506_0708, 1'b1, 1'b0);
        send_header();
        get_result(0);
        build(4'd4, 4'd7, 16'd27, 8'h01, 32'h0102_0304, 32'h0506_0708, 1'b1, 1'b0);
        send_header();
        get_result(0);

        // Backpressure with the next header's first word waiting
        build(4'd4, 4'd5, 16'd100, 8'h11, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        send_header();
        bus.in_valid = 1'b1;
        bus.in_sop   = 1'b1;
        bus.in_data  = 32'h4500_0073;
        get_result(10);
        set_ref_hdr();
        send_header();
        get_result(0);

        // in_sop at word 3 aborts the partial header
        build(4'd4, 4'd5, 16'd60, 8'h06, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(hdr[i], (i == 0));
        exp_abort++;
        set_ref_hdr();
        send_header();
        get_result(0);
`ifdef IPV4_CHK_STATS_EN
        check("stat_abort", 64'(stat_abort), 64'(exp_abort));
`endif

        // Reset at word 3 discards the partial header
        build(4'd4, 4'd5, 16'd60, 8'h06, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_word(hdr[i], (i == 0));
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        exp_good  = 0;
        exp_bad   = 0;
        exp_abort = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_no_valid", 64'(bus.res_valid), 64'd0);
        end
        check_idle_outputs("mid_reset");

        // Randomized headers
        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(0, 9);
            ihl = (r == 0) ? 4'd4 : (r == 1) ? 4'd6 : (r == 2) ? 4'd7 :
                  (r == 3) ? 4'd15 : (r == 4) ? 4'($urandom_range(0, 3)) : 4'd5;
            ver  = ($urandom_range(0, 7) == 0) ? 4'd6 : 4'd4;
            tlen = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 70))
                                               : 16'($urandom_range(60, 1500));
            if ($urandom_range(0, 5) == 0) send_word(32'($urandom), 1'b0);
            build(ver, ihl, tlen, 8'($urandom), 32'($urandom), 32'($urandom),
                  1'b1, ($urandom_range(0, 3) == 0));
            send_header();
            get_result($urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
